// File: rtl/datapath_pkg.sv
// Shared definitions for the single-bus datapath: bus width and ALU opcodes.
// Latency: n/a (constants only).
// Backpressure: n/a.
package datapath_pkg;

    localparam int WIDTH = 32;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A (from Y) op B (from bus) -> 64-bit {hi,lo} result.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the result is captured by Z when the sequencer enables it.
module alu
    import datapath_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [4:0]     op_code,
    output logic [2*W-1:0] result
);

    localparam int SW = $clog2(W);

    logic [SW-1:0]  sh;
    logic [2*W-1:0] dbl;
    logic [2*W-1:0] a_ext;
    logic [2*W-1:0] b_ext;
    logic [2*W-1:0] dbl_ror;
    logic [2*W-1:0] dbl_rol;

    assign sh      = b[SW-1:0];
    assign dbl     = {a, a};
    // Sign-extend both operands so an unsigned 2W-bit multiply yields the signed product.
    assign a_ext   = {{W{a[W-1]}}, a};
    assign b_ext   = {{W{b[W-1]}}, b};
    // Rotations fall out of shifting the doubled operand and keeping one half.
    assign dbl_ror = dbl >> sh;
    assign dbl_rol = dbl << sh;

    // Opcode decode; unlisted opcodes produce zero.
    always_comb begin
        result = '0;
        unique case (op_code)
            OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI:
                result[W-1:0] = a + b;
            OP_SUB:           result[W-1:0] = a - b;
            OP_AND, OP_ANDI:  result[W-1:0] = a & b;
            OP_OR, OP_ORI:    result[W-1:0] = a | b;
            OP_ROR:           result[W-1:0] = dbl_ror[W-1:0];
            OP_ROL:           result[W-1:0] = dbl_rol[2*W-1:W];
            OP_SHR:           result[W-1:0] = a >> sh;
            OP_SHRA:          result[W-1:0] = $unsigned($signed(a) >>> sh);
            OP_SHL:           result[W-1:0] = a << sh;
            OP_DIV: begin
                // Divide by zero is defined: quotient 0, remainder is the dividend.
                if (b == '0) begin
                    result = {a, {W{1'b0}}};
                end else begin
                    result[W-1:0]   = $unsigned($signed(a) / $signed(b));
                    result[2*W-1:W] = $unsigned($signed(a) % $signed(b));
                end
            end
            OP_MUL:           result = a_ext * b_ext;
            OP_NEG:           result[W-1:0] = '0 - b;
            OP_NOT:           result[W-1:0] = ~b;
            default:          result = '0;
        endcase
    end

endmodule

// File: rtl/datapath.sv
// Single-bus CPU datapath: PC, IR, MAR, MDR, Y, Z(hi/lo), R3/R4/R7 around one shared bus.
// Latency: 1 cycle register-to-register; ALU op is Y load then Z load (2 cycles).
// Backpressure: none; an external sequencer drives every select/enable each cycle.
module datapath
    import datapath_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         pc_out,
    input  logic         zlo_out,
    input  logic         zhi_out,
    input  logic         mdr_out,
    input  logic         r3_out,
    input  logic         r4_out,
    input  logic         r7_out,
    input  logic         pc_enable,
    input  logic         mar_enable,
    input  logic         mdr_enable,
    input  logic         ir_enable,
    input  logic         y_enable,
    input  logic         z_enable,
    input  logic         r3_enable,
    input  logic         r4_enable,
    input  logic         r7_enable,
    input  logic         pc_increment,
    input  logic         read,
    input  logic [4:0]   op_code,
    input  logic [W-1:0] m_data_in,
    output logic [W-1:0] bus_q,
    output logic [W-1:0] pc_q,
    output logic [W-1:0] mar_q,
    output logic [W-1:0] ir_q,
    output logic [W-1:0] mdr_q,
    output logic [W-1:0] y_q,
    output logic [W-1:0] zlo_q,
    output logic [W-1:0] zhi_q,
    output logic [W-1:0] r3_q,
    output logic [W-1:0] r4_q,
    output logic [W-1:0] r7_q
);

    logic [2*W-1:0] alu_result;

    // Fixed-priority bus source mux; idle bus reads as zero.
    always_comb begin
        bus_q = '0;
        if      (pc_out)  bus_q = pc_q;
        else if (mdr_out) bus_q = mdr_q;
        else if (zlo_out) bus_q = zlo_q;
        else if (zhi_out) bus_q = zhi_q;
        else if (r3_out)  bus_q = r3_q;
        else if (r4_out)  bus_q = r4_q;
        else if (r7_out)  bus_q = r7_q;
    end

    alu #(.W(W)) u_alu (
        .a       (y_q),
        .b       (bus_q),
        .op_code (op_code),
        .result  (alu_result)
    );

    // PC: an explicit load wins over the increment, which wraps naturally.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)              pc_q <= '0;
        else if (pc_enable)    pc_q <= bus_q;
        else if (pc_increment) pc_q <= pc_q + 1'b1;
    end

    // MDR: memory read data or bus, chosen by read.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)           mdr_q <= '0;
        else if (mdr_enable) mdr_q <= read ? m_data_in : bus_q;
    end

    // Z captures the full 64-bit ALU result in one edge.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            zhi_q <= '0;
            zlo_q <= '0;
        end else if (z_enable) begin
            zhi_q <= alu_result[2*W-1:W];
            zlo_q <= alu_result[W-1:0];
        end
    end

    // Plain bus-loaded registers; each holds when its enable is low.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            mar_q <= '0;
            ir_q  <= '0;
            y_q   <= '0;
            r3_q  <= '0;
            r4_q  <= '0;
            r7_q  <= '0;
        end else begin
            if (mar_enable) mar_q <= bus_q;
            if (ir_enable)  ir_q  <= bus_q;
            if (y_enable)   y_q   <= bus_q;
            if (r3_enable)  r3_q  <= bus_q;
            if (r4_enable)  r4_q  <= bus_q;
            if (r7_enable)  r7_q  <= bus_q;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// Directed bench for the single-bus datapath with hand-computed expectations.
// Latency: each step drives controls, waits one rising edge, samples 1 time unit later.
// Backpressure: n/a.
module tb_datapath;

    logic        clk = 1'b0;
    logic        clr;
    logic        pc_out, zlo_out, zhi_out, mdr_out, r3_out, r4_out, r7_out;
    logic        pc_enable, mar_enable, mdr_enable, ir_enable, y_enable, z_enable;
    logic        r3_enable, r4_enable, r7_enable, pc_increment, read;
    logic [4:0]  op_code;
    logic [31:0] m_data_in;
    logic [31:0] bus_q, pc_q, mar_q, ir_q, mdr_q, y_q, zlo_q, zhi_q, r3_q, r4_q, r7_q;

    int checks   = 0;
    int failures = 0;

    datapath dut (
        .clk(clk), .clr(clr),
        .pc_out(pc_out), .zlo_out(zlo_out), .zhi_out(zhi_out), .mdr_out(mdr_out),
        .r3_out(r3_out), .r4_out(r4_out), .r7_out(r7_out),
        .pc_enable(pc_enable), .mar_enable(mar_enable), .mdr_enable(mdr_enable),
        .ir_enable(ir_enable), .y_enable(y_enable), .z_enable(z_enable),
        .r3_enable(r3_enable), .r4_enable(r4_enable), .r7_enable(r7_enable),
        .pc_increment(pc_increment), .read(read), .op_code(op_code),
        .m_data_in(m_data_in), .bus_q(bus_q),
        .pc_q(pc_q), .mar_q(mar_q), .ir_q(ir_q), .mdr_q(mdr_q), .y_q(y_q),
        .zlo_q(zlo_q), .zhi_q(zhi_q), .r3_q(r3_q), .r4_q(r4_q), .r7_q(r7_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        {pc_out, zlo_out, zhi_out, mdr_out, r3_out, r4_out, r7_out} = '0;
        {pc_enable, mar_enable, mdr_enable, ir_enable, y_enable, z_enable} = '0;
        {r3_enable, r4_enable, r7_enable, pc_increment, read} = '0;
        op_code   = 5'b00000;
        m_data_in = '0;
    endtask

    // Apply the currently driven controls for one edge, then return to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic mdr_load(input logic [31:0] v);
        read = 1'b1; mdr_enable = 1'b1; m_data_in = v;
        tick();
    endtask

    task automatic alu_op(input logic [4:0] op);
        mdr_out = 1'b1; op_code = op; z_enable = 1'b1;
        tick();
    endtask

    initial begin
        idle();
        clr = 1'b0;
        #12;
        check("rst_pc",  pc_q,  32'h0);
        check("rst_mdr", mdr_q, 32'h0);
        check("rst_zhi", zhi_q, 32'h0);
        check("rst_bus", bus_q, 32'h0);
        clr = 1'b1;
        @(negedge clk);

        // Async reset mid-cycle clears a loaded register with no edge.
        mdr_load(32'h22);
        mdr_out = 1'b1; r3_enable = 1'b1; tick();
        check("r3_load", r3_q, 32'h22);
        #2 clr = 1'b0;
        #1;
        check("async_r3",  r3_q,  32'h0);
        check("async_mdr", mdr_q, 32'h0);
        check("async_bus", bus_q, 32'h0);
        #1 clr = 1'b1;

        // SHL sequence with write-back to R4.
        mdr_load(32'h22); mdr_out = 1'b1; r3_enable = 1'b1; tick();
        mdr_load(32'h4);  mdr_out = 1'b1; r7_enable = 1'b1; tick();
        mdr_load(32'h28); mdr_out = 1'b1; r4_enable = 1'b1; tick();
        check("r4_pre", r4_q, 32'h28);
        r3_out = 1'b1; y_enable = 1'b1; tick();
        check("y_r3", y_q, 32'h22);
        r7_out = 1'b1; op_code = 5'b01011; z_enable = 1'b1;
        #1 check("bus_r7", bus_q, 32'h4);
        tick();
        check("shl_lo", zlo_q, 32'h220);
        check("shl_hi", zhi_q, 32'h0);
        zlo_out = 1'b1; r4_enable = 1'b1; tick();
        check("wb_r4", r4_q, 32'h220);
        r4_out = 1'b1; r4_enable = 1'b1; tick();
        check("self_hold", r4_q, 32'h220);
        r3_out = 1'b1; r4_out = 1'b1;
        #1 check("prio_r3_r4", bus_q, 32'h22);
        idle();
        zhi_out = 1'b1; r3_out = 1'b1;
        #1 check("prio_zhi_r3", bus_q, 32'h0);
        idle();

        // Fetch.
        mdr_load(32'h5); mdr_out = 1'b1; pc_enable = 1'b1; tick();
        check("pc_5", pc_q, 32'h5);
        pc_out = 1'b1; mar_enable = 1'b1; pc_increment = 1'b1; tick();
        check("fetch_mar", mar_q, 32'h5);
        check("fetch_pc",  pc_q,  32'h6);
        mdr_load(32'h5A1B8000);
        check("fetch_mdr", mdr_q, 32'h5A1B8000);
        mdr_out = 1'b1; ir_enable = 1'b1; tick();
        check("fetch_ir", ir_q, 32'h5A1B8000);

        // MUL -2*3.
        mdr_load(32'hFFFFFFFE); mdr_out = 1'b1; y_enable = 1'b1; tick();
        mdr_load(32'h3); alu_op(5'b10000);
        check("mul_hi", zhi_q, 32'hFFFFFFFF);
        check("mul_lo", zlo_q, 32'hFFFFFFFA);
        // DIV -7/2.
        mdr_load(32'hFFFFFFF9); mdr_out = 1'b1; y_enable = 1'b1; tick();
        mdr_load(32'h2); alu_op(5'b01111);
        check("div_lo", zlo_q, 32'hFFFFFFFD);
        check("div_hi", zhi_q, 32'hFFFFFFFF);
        // DIV 9/0 on an idle (zero) bus.
        mdr_load(32'h9); mdr_out = 1'b1; y_enable = 1'b1; tick();
        op_code = 5'b01111; z_enable = 1'b1; tick();
        check("div0_lo", zlo_q, 32'h0);
        check("div0_hi", zhi_q, 32'h9);

        // Shifts, rotates and a few arithmetic ops on Y=0x80000001, B=1.
        mdr_load(32'h80000001); mdr_out = 1'b1; y_enable = 1'b1; tick();
        mdr_load(32'h1);
        alu_op(5'b00111); check("ror",  zlo_q, 32'hC0000000);
        alu_op(5'b01000); check("rol",  zlo_q, 32'h00000003);
        alu_op(5'b01001); check("shr",  zlo_q, 32'h40000000);
        alu_op(5'b01010); check("shra", zlo_q, 32'hC0000000);
        check("shra_hi", zhi_q, 32'h0);
        alu_op(5'b00011); check("add",  zlo_q, 32'h80000002);
        alu_op(5'b00100); check("sub",  zlo_q, 32'h80000000);
        alu_op(5'b00101); check("and",  zlo_q, 32'h00000001);
        alu_op(5'b01110); check("ori",  zlo_q, 32'h80000001);
        alu_op(5'b10001); check("neg",  zlo_q, 32'hFFFFFFFF);
        alu_op(5'b10010); check("not",  zlo_q, 32'hFFFFFFFE);
        alu_op(5'b11111); check("bad_op", zlo_q, 32'h0);

        // Bus priority with PC, PC load priority and wrap.
        pc_out = 1'b1; r3_out = 1'b1;
        #1 check("prio_pc", bus_q, 32'h6);
        idle();
        mdr_load(32'h100);
        mdr_out = 1'b1; pc_enable = 1'b1; pc_increment = 1'b1; tick();
        check("pc_load_prio", pc_q, 32'h100);
        mdr_load(32'hFFFFFFFF); mdr_out = 1'b1; pc_enable = 1'b1; tick();
        pc_increment = 1'b1; tick();
        check("pc_wrap", pc_q, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- 32-bit single-bus CPU datapath for the Phase 1 processor: PC, IR, MAR, MDR, Y, 64-bit Z (ZHI/ZLO), general registers R3/R4/R7 and a combinational ALU.
- Every register sources from and sinks to one shared 32-bit bus.
- An external control sequencer drives all out-selects, enables and op_code each cycle; memory data enters only through the MDR.

Parameters:
- WIDTH, 32, datapath/bus width; all registers are WIDTH bits, Z is 2*WIDTH.

Ports:
- clk  in  1  system clock; all registers update on rising edge.
- clr  in  1  asynchronous active-low reset; 0 clears every register immediately.
- pc_out, zlo_out, zhi_out, mdr_out, r3_out, r4_out, r7_out  in  1 each  bus source selects.
- pc_enable, mar_enable, mdr_enable, ir_enable, y_enable, z_enable, r3_enable, r4_enable, r7_enable  in  1 each  register load enables.
- pc_increment  in  1  PC <= PC+1.
- read  in  1  MDR input mux: 1 = m_data_in, 0 = bus.
- op_code  in  5  ALU operation.
- m_data_in  in  WIDTH  memory read data.
- bus_q  out  WIDTH  current bus value.
- pc_q, mar_q, ir_q, mdr_q, y_q, zlo_q, zhi_q, r3_q, r4_q, r7_q  out  WIDTH each  register contents for observation.

Behaviour:
- Reset: while clr=0, every register is 0, so all *_q outputs are 0 and bus_q is 0. Reset is asynchronous and overrides any load in progress. Operation resumes on the first rising edge after clr returns to 1.
- Bus: combinational mux with fixed priority when several selects are high: pc_out > mdr_out > zlo_out > zhi_out > r3_out > r4_out > r7_out. With no select active the bus is 0. The bus is never tri-stated.
- Register loads take effect at the rising edge:
  - R3/R4/R7, MAR, IR, Y load the bus when their enable is 1; otherwise they hold.
  - MDR loads (read ? m_data_in : bus) when mdr_enable=1.
  - PC: pc_enable=1 loads the bus, and pc_enable has priority over pc_increment. pc_increment=1 alone gives PC <= PC+1, wrapping 0xFFFFFFFF to 0.
  - PC driven onto the bus with mar_enable and pc_increment in the same cycle gives MAR = old PC and PC = old PC+1.
- All loads sample the bus value present before the edge, so a register both driving the bus and loading it retains its own value.
- ALU is combinational: A = Y, B = bus; result is 64 bits {hi,lo}. On z_enable=1, ZHI <= hi and ZLO <= lo. Opcodes, with hi=0 unless stated:
  - 00000 ld, 00001 ldi, 00010 st, 00011 add, 01100 addi: lo = A+B, mod 2^32.
  - 00100 sub: lo = A-B.
  - 00101 and, 01101 andi: lo = A&B.
  - 00110 or, 01110 ori: lo = A|B.
  - Shifts use amount B[4:0]: 00111 ror = rotate A right; 01000 rol = rotate A left; 01001 shr = logical right; 01010 shra = arithmetic right; 01011 shl = logical left.
  - 01111 div: signed; lo = quotient truncated toward zero, hi = remainder with the sign of A. When B=0: lo = 0, hi = A.
  - 10000 mul: signed 64-bit product {hi,lo}.
  - 10001 neg: lo = -B.
  - 10010 not: lo = ~B.
  - Any other opcode: result 0.
- Data written back from Z reaches the bus only through zlo_out/zhi_out, one cycle after z_enable.
- Latency: register to register takes 1 cycle; an ALU operation takes 2 cycles (Y load, then Z load), and 3 including write-back.

Decomposition:
- Shared package: WIDTH and the 5-bit opcode constants listed above.
- Sub-module: alu (combinational; A, B, op_code in, 64-bit result out).
- Registers and the bus mux stay in datapath.

Test Plan:
- Reset: load R3=0x22, then pulse clr=0 mid-cycle -> all *_q read 0 immediately, with no edge required.
- SHL: MDR<-m_data_in 0x22 -> R3; 0x4 -> R7; 0x28 -> R4; R3->Y; R7 on bus with op_code 01011 and z_enable -> ZLO=0x220, ZHI=0; zlo_out+r4_enable -> R4=0x220.
- Fetch: PC=5, assert pc_out+mar_enable+pc_increment -> MAR=5, PC=6. Then m_data_in=0x5A1B8000 with read+mdr_enable, then mdr_out+ir_enable -> IR=0x5A1B8000.
- MUL/DIV: Y=0xFFFFFFFE (-2), bus=3, op 10000 -> ZHI=0xFFFFFFFF, ZLO=0xFFFFFFFA. Y=-7, bus=2, op 01111 -> ZLO=0xFFFFFFFD, ZHI=0xFFFFFFFF. Y=9, bus=0 -> ZLO=0, ZHI=9.
- Shifts/rotates: Y=0x80000001, bus=1 -> ror=0xC0000000, rol=0x00000003, shr=0x40000000, shra=0xC0000000.
- Bus priority and PC: pc_out and r3_out together -> bus_q=PC. pc_enable with pc_increment and bus=0x100 -> PC=0x100. PC=0xFFFFFFFF with pc_increment -> PC=0.
